rejection_sampler_ctrl: RTL and testbench

Initiator side of the rejection-sampling decision interface in the CBD sampler path. Consumes raw entropy words, splits each into a signed candidate and a random comparison value, and presents them to an external combinational acceptance filter. Accepted candidates are buffered and streamed out with a per-sample retry count; rejected candidates are discarded and the next entropy word is fetched.

---
 rtl/rej_sampler_pkg.sv | 33 +++
 rtl/rej_sample_fifo.sv | 55 +++++
 rtl/rejection_sampler_ctrl.sv | 145 ++++++++++++++
 tb/tb_rejection_sampler_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rej_sampler_pkg.sv
// Shared definitions for the rejection sampler: entropy field layout helpers,
// retry-counter width function and the default-width sample record.
package rej_sampler_pkg;

   localparam int DEF_VALUE_WIDTH = 4;
   localparam int DEF_RAND_WIDTH  = 8;
   localparam int DEF_MAX_RETRY   = 15;

   function automatic int retry_width(input int max_retry);
      return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
   endfunction

   function automatic int ent_width(input int value_width, input int rand_width);
      return 1 + value_width + rand_width;
   endfunction

   // Entropy word is {sign, magnitude, random}, MSB first.
   function automatic int sign_pos(input int value_width, input int rand_width);
      return value_width + rand_width;
   endfunction

   function automatic int mag_lsb(input int rand_width);
      return rand_width;
   endfunction

   localparam int DEF_RETRY_WIDTH = retry_width(DEF_MAX_RETRY);

   typedef struct packed {
      logic [DEF_VALUE_WIDTH:0]   value;
      logic [DEF_RETRY_WIDTH-1:0] retry;
   } sample_t;

endpackage

// File: rtl/rej_sample_fifo.sv
// Synchronous FIFO with head-of-queue output, occupancy count and
// simultaneous push/pop allowed while full.
module rej_sample_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == CW'(DEPTH));
   assign count    = count_reg;
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   // Gate the head so the output reads zero when nothing is buffered.
   assign pop_data = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/rejection_sampler_ctrl.sv
// Rejection-sampling initiator: holds one candidate for the external filter,
// buffers accepted samples with their retry count. Optional REJ_SAMPLER_STATS_EN.
module rejection_sampler_ctrl
   import rej_sampler_pkg::*;
#(
   parameter  int VALUE_WIDTH = 4,
   parameter  int RAND_WIDTH  = 8,
   parameter  int FIFO_DEPTH  = 4,
   parameter  int MAX_RETRY   = 15,
   localparam int ENT_WIDTH   = ent_width(VALUE_WIDTH, RAND_WIDTH),
   localparam int RETRY_WIDTH = retry_width(MAX_RETRY)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ent_valid,
   output logic                   ent_ready,
   input  logic [ENT_WIDTH-1:0]   ent_data,
   output logic [VALUE_WIDTH-1:0] flt_magnitude,
   output logic [RAND_WIDTH-1:0]  flt_random,
   input  logic                   flt_accept,
   output logic                   smp_valid,
   input  logic                   smp_ready,
   output logic [VALUE_WIDTH:0]   smp_data,
   output logic [RETRY_WIDTH-1:0] smp_retry,
`ifdef REJ_SAMPLER_STATS_EN
   output logic [31:0]            stat_accepted,
   output logic [31:0]            stat_rejected,
`endif
   output logic                   retry_err
);

   localparam int SIGN_POS = sign_pos(VALUE_WIDTH, RAND_WIDTH);
   localparam int MAG_LSB  = mag_lsb(RAND_WIDTH);
   localparam int FW       = VALUE_WIDTH + 1 + RETRY_WIDTH;
   localparam int CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [RETRY_WIDTH-1:0] RETRY_MAX = RETRY_WIDTH'(MAX_RETRY);

   logic                   cand_valid_reg, cand_valid_next;
   logic                   cand_sign_reg, cand_sign_next;
   logic [VALUE_WIDTH-1:0] cand_mag_reg, cand_mag_next;
   logic [RAND_WIDTH-1:0]  cand_rnd_reg, cand_rnd_next;
   logic [RETRY_WIDTH-1:0] retry_cnt_reg, retry_cnt_next;
   logic                   retry_err_reg, retry_err_next;

   logic                   pop, push_ok, accept_push, reject, consumed, ent_fire;
   logic [VALUE_WIDTH:0]   mag_ext, sample_value;
   logic [FW-1:0]          fifo_out;
   logic [CW-1:0]          fifo_count;
   logic                   fifo_empty, fifo_full;

   assign pop         = smp_valid & smp_ready;
   assign push_ok     = (fifo_count < CW'(FIFO_DEPTH)) | pop;
   assign accept_push = cand_valid_reg & flt_accept & push_ok;
   assign reject      = cand_valid_reg & ~flt_accept;
   assign consumed    = accept_push | reject;
   assign ent_ready   = ~cand_valid_reg | consumed;
   assign ent_fire    = ent_valid & ent_ready;

   // Two's-complement negate; a negative zero falls out as zero.
   assign mag_ext      = {1'b0, cand_mag_reg};
   assign sample_value = cand_sign_reg ? (~mag_ext + 1'b1) : mag_ext;

   assign flt_magnitude = cand_valid_reg ? cand_mag_reg : '0;
   assign flt_random    = cand_valid_reg ? cand_rnd_reg : '0;
   assign retry_err     = retry_err_reg;

   always_comb begin
      cand_valid_next = cand_valid_reg;
      cand_sign_next  = cand_sign_reg;
      cand_mag_next   = cand_mag_reg;
      cand_rnd_next   = cand_rnd_reg;
      retry_cnt_next  = retry_cnt_reg;
      if (ent_fire) begin
         cand_valid_next = 1'b1;
         cand_sign_next  = ent_data[SIGN_POS];
         cand_mag_next   = ent_data[SIGN_POS-1 -: VALUE_WIDTH];
         cand_rnd_next   = ent_data[MAG_LSB-1:0];
      end else if (consumed) begin
         cand_valid_next = 1'b0;
      end
      if (reject && retry_cnt_reg != RETRY_MAX)
         retry_cnt_next = retry_cnt_reg + RETRY_WIDTH'(1);
      else if (accept_push)
         retry_cnt_next = '0;
      retry_err_next = retry_err_reg |
                       ((retry_cnt_next == RETRY_MAX) && (retry_cnt_reg != RETRY_MAX));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand_valid_reg <= 1'b0;
         cand_sign_reg  <= 1'b0;
         cand_mag_reg   <= '0;
         cand_rnd_reg   <= '0;
         retry_cnt_reg  <= '0;
         retry_err_reg  <= 1'b0;
      end else begin
         cand_valid_reg <= cand_valid_next;
         cand_sign_reg  <= cand_sign_next;
         cand_mag_reg   <= cand_mag_next;
         cand_rnd_reg   <= cand_rnd_next;
         retry_cnt_reg  <= retry_cnt_next;
         retry_err_reg  <= retry_err_next;
      end
   end

   rej_sample_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (accept_push),
      .push_data ({sample_value, retry_cnt_reg}),
      .pop       (pop),
      .pop_data  (fifo_out),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign smp_valid = ~fifo_empty;
   assign smp_data  = fifo_out[FW-1 -: VALUE_WIDTH+1];
   assign smp_retry = fifo_out[RETRY_WIDTH-1:0];

`ifdef REJ_SAMPLER_STATS_EN
   logic [31:0] stat_accepted_reg, stat_rejected_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_accepted_reg <= '0;
         stat_rejected_reg <= '0;
      end else begin
         if (accept_push && stat_accepted_reg != '1)
            stat_accepted_reg <= stat_accepted_reg + 32'd1;
         if (reject && stat_rejected_reg != '1)
            stat_rejected_reg <= stat_rejected_reg + 32'd1;
      end
   end

   assign stat_accepted = stat_accepted_reg;
   assign stat_rejected = stat_rejected_reg;
`endif

endmodule

// File: tb/tb_rejection_sampler_ctrl.sv
// Directed bench for rejection_sampler_ctrl with the BASE_LIMIT=200,
// SHIFT_FACTOR=4 acceptance filter modelled inline.
module tb_rejection_sampler_ctrl;
   import rej_sampler_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ent_valid = 1'b0;
   logic        ent_ready;
   logic [12:0] ent_data = '0;
   logic [3:0]  flt_magnitude;
   logic [7:0]  flt_random;
   logic        flt_accept;
   logic        smp_valid;
   logic        smp_ready = 1'b0;
   logic [4:0]  smp_data;
   logic [3:0]  smp_retry;
   logic        retry_err;
`ifdef REJ_SAMPLER_STATS_EN
   logic [31:0] stat_accepted, stat_rejected;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Filter: limit = 200 - mag*16, floored at 0; accept when rnd < limit.
   int limit;
   always_comb begin
      limit      = (int'(flt_magnitude) * 16 >= 200) ? 0 : 200 - int'(flt_magnitude) * 16;
      flt_accept = (int'(flt_random) < limit);
   end

   rejection_sampler_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ent_valid     (ent_valid),
      .ent_ready     (ent_ready),
      .ent_data      (ent_data),
      .flt_magnitude (flt_magnitude),
      .flt_random    (flt_random),
      .flt_accept    (flt_accept),
      .smp_valid     (smp_valid),
      .smp_ready     (smp_ready),
      .smp_data      (smp_data),
      .smp_retry     (smp_retry),
`ifdef REJ_SAMPLER_STATS_EN
      .stat_accepted (stat_accepted),
      .stat_rejected (stat_rejected),
`endif
      .retry_err     (retry_err)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Offers one entropy word; returns one cycle after the handshake edge.
   task automatic send(input logic s, input logic [3:0] m, input logic [7:0] r);
      bit done = 1'b0;
      ent_valid = 1'b1;
      ent_data  = {s, m, r};
      for (int i = 0; i < 40 && !done; i++) begin
         #1;
         if (ent_ready) done = 1'b1;
         @(posedge clk); #1;
      end
      ent_valid = 1'b0;
      if (!done) begin
         tests++; fails++;
         $display("FAIL send_timeout: ent_ready=%0b required 1", ent_ready);
      end
   endtask

   task automatic get_sample(output logic [4:0] d, output logic [3:0] rt);
      bit got = 1'b0;
      d = '0; rt = '0;
      smp_ready = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         #1;
         if (smp_valid) begin d = smp_data; rt = smp_retry; got = 1'b1; end
         @(posedge clk); #1;
      end
      smp_ready = 1'b0;
      if (!got) begin
         tests++; fails++;
         $display("FAIL sample_timeout: smp_valid=%0b required 1", smp_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      tests++; if (ent_ready !== 1'b1) begin fails++; $display("FAIL reset_ent_ready: got %0b want 1", ent_ready); end
      tests++; if (smp_valid !== 1'b0) begin fails++; $display("FAIL reset_smp_valid: got %0b want 0", smp_valid); end
      tests++; if (smp_data !== 5'd0) begin fails++; $display("FAIL reset_smp_data: got %b want 00000", smp_data); end
      tests++; if (smp_retry !== 4'd0) begin fails++; $display("FAIL reset_smp_retry: got %0d want 0", smp_retry); end
      tests++; if (retry_err !== 1'b0) begin fails++; $display("FAIL reset_retry_err: got %0b want 0", retry_err); end
      tests++; if (flt_magnitude !== 4'd0 || flt_random !== 8'd0) begin
         fails++; $display("FAIL reset_flt: got mag=%0d rnd=%0d want 0/0", flt_magnitude, flt_random); end
      @(posedge clk); #1;
      $display("[TB] reset checked");
   endtask

   task automatic test_single();
      send(1'b1, 4'd3, 8'd100);
      tests++; if (flt_magnitude !== 4'd3 || flt_random !== 8'd100) begin
         fails++; $display("FAIL single_flt: got mag=%0d rnd=%0d want 3/100", flt_magnitude, flt_random); end
      tests++; if (smp_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %0b want 0", smp_valid); end
      @(posedge clk); #1;
      tests++; if (smp_valid !== 1'b1) begin fails++; $display("FAIL single_latency: smp_valid got %0b want 1", smp_valid); end
      tests++; if (smp_data !== 5'b11101 || smp_retry !== 4'd0) begin
         fails++; $display("FAIL single_data: got %b/%0d want 11101/0", smp_data, smp_retry); end
      smp_ready = 1'b1;
      @(posedge clk); #1;
      smp_ready = 1'b0;
      tests++; if (smp_valid !== 1'b0) begin fails++; $display("FAIL single_drain: smp_valid got %0b want 0", smp_valid); end
      $display("[TB] single word -3 checked");
   endtask

   task automatic test_retry();
      logic [4:0] d; logic [3:0] rt;
      send(1'b0, 4'd13, 8'd0);
      send(1'b0, 4'd13, 8'd0);
      send(1'b0, 4'd2, 8'd10);
      get_sample(d, rt);
      tests++; if (d !== 5'b00010 || rt !== 4'd2) begin
         fails++; $display("FAIL retry_count: got %b/%0d want 00010/2", d, rt); end
      $display("[TB] two rejects then +2 checked");
   endtask

   task automatic test_retry_err();
      logic [4:0] d; logic [3:0] rt;
      for (int i = 0; i < 14; i++) send(1'b0, 4'd13, 8'd0);
      @(posedge clk); #1;
      tests++; if (retry_err !== 1'b0) begin fails++; $display("FAIL retry_err_early: got %0b want 0 after 14 rejects", retry_err); end
      send(1'b0, 4'd13, 8'd0);
      @(posedge clk); #1;
      tests++; if (retry_err !== 1'b1) begin fails++; $display("FAIL retry_err_set: got %0b want 1 after 15 rejects", retry_err); end
      send(1'b0, 4'd1, 8'd0);
      get_sample(d, rt);
      tests++; if (d !== 5'b00001 || rt !== 4'd15) begin
         fails++; $display("FAIL retry_sat_sample: got %b/%0d want 00001/15", d, rt); end
      tests++; if (retry_err !== 1'b1) begin fails++; $display("FAIL retry_err_sticky: got %0b want 1", retry_err); end
      $display("[TB] retry_err and saturated retry checked");
   endtask

   task automatic test_backpressure();
      sample_t exp_s [5];
      logic [4:0] d; logic [3:0] rt;
      exp_s[0] = '{value: 5'b00001, retry: 4'd0};
      exp_s[1] = '{value: 5'b11110, retry: 4'd0};
      exp_s[2] = '{value: 5'b00011, retry: 4'd0};
      exp_s[3] = '{value: 5'b11100, retry: 4'd0};
      exp_s[4] = '{value: 5'b00101, retry: 4'd0};
      smp_ready = 1'b0;
      send(1'b0, 4'd1, 8'd5);
      send(1'b1, 4'd2, 8'd6);
      send(1'b0, 4'd3, 8'd7);
      send(1'b1, 4'd4, 8'd8);
      send(1'b0, 4'd5, 8'd9);
      @(posedge clk); #1;
      tests++; if (ent_ready !== 1'b0) begin fails++; $display("FAIL bp_stall_ready: got %0b want 0", ent_ready); end
      tests++; if (flt_magnitude !== 4'd5 || flt_random !== 8'd9) begin
         fails++; $display("FAIL bp_flt_hold: got mag=%0d rnd=%0d want 5/9", flt_magnitude, flt_random); end
      tests++; if (smp_valid !== 1'b1 || smp_data !== 5'b00001) begin
         fails++; $display("FAIL bp_head_hold: got valid=%0b data=%b want 1/00001", smp_valid, smp_data); end
      for (int i = 0; i < 5; i++) begin
         get_sample(d, rt);
         tests++; if (d !== exp_s[i].value || rt !== exp_s[i].retry) begin
            fails++; $display("FAIL bp_order[%0d]: got %b/%0d want %b/%0d", i, d, rt, exp_s[i].value, exp_s[i].retry); end
      end
      #1;
      tests++; if (smp_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: smp_valid got %0b want 0", smp_valid); end
      $display("[TB] backpressure with full FIFO checked");
   endtask

   task automatic test_neg_zero();
      logic [4:0] d; logic [3:0] rt;
      send(1'b1, 4'd0, 8'd0);
      get_sample(d, rt);
      tests++; if (d !== 5'b00000 || rt !== 4'd0) begin
         fails++; $display("FAIL neg_zero: got %b/%0d want 00000/0", d, rt); end
      $display("[TB] negative zero checked");
   endtask

   task automatic test_back_to_back();
      smp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k < 4) begin
            ent_valid = 1'b1;
            ent_data  = {1'b0, 4'(k + 1), 8'd0};
         end else begin
            ent_valid = 1'b0;
         end
         #1;
         if (k < 4) begin
            tests++; if (ent_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %0b want 1", k, ent_ready); end
         end
         if (k >= 2) begin
            tests++; if (smp_valid !== 1'b1 || smp_data !== 5'(k - 1)) begin
               fails++; $display("FAIL b2b_out[%0d]: got valid=%0b data=%0d want 1/%0d", k, smp_valid, smp_data, k - 1); end
         end
         @(posedge clk); #1;
      end
      smp_ready = 1'b0;
      $display("[TB] back-to-back throughput checked");
   endtask

   task automatic test_reset_mid();
      smp_ready = 1'b0;
      send(1'b0, 4'd1, 8'd0);
      send(1'b0, 4'd2, 8'd0);
      send(1'b0, 4'd3, 8'd0);
      @(posedge clk); #1;
      tests++; if (smp_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid: got %0b want 1", smp_valid); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      tests++; if (smp_valid !== 1'b0) begin fails++; $display("FAIL mid_smp_valid: got %0b want 0", smp_valid); end
      tests++; if (retry_err !== 1'b0) begin fails++; $display("FAIL mid_retry_err: got %0b want 0", retry_err); end
      tests++; if (ent_ready !== 1'b1 || flt_magnitude !== 4'd0) begin
         fails++; $display("FAIL mid_cand: got ready=%0b mag=%0d want 1/0", ent_ready, flt_magnitude); end
      smp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests++; if (smp_valid !== 1'b0) begin fails++; $display("FAIL mid_stale[%0d]: smp_valid got %0b want 0", i, smp_valid); end
         @(posedge clk); #1;
      end
      smp_ready = 1'b0;
      $display("[TB] reset mid-operation checked");
   endtask

   initial begin
      test_reset();
      test_single();
      test_retry();
      test_retry_err();
      test_backpressure();
      test_neg_zero();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
